// File: rtl/tamagotchi_btn_conditioner_pkg.sv
// tamagotchi_pkg: shared button indices, debounce state encoding and default timing constants
package tamagotchi_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int SEC_CYCLES_DEF = 50000000;
    localparam int HOLD_MAX_DEF = 5;
    localparam int NUM_BTN = 6;
    localparam int SALUD = 0;
    localparam int ENERGIA = 1;
    localparam int HAMBRE = 2;
    localparam int DIVERSION = 3;
    localparam int RESET = 4;
    localparam int TEST = 5;
    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} db_state_t;
endpackage

// File: rtl/tamagotchi_btn_conditioner_if.sv
// tamagotchi_btn_conditioner_if: raw active-low buttons in, conditioned pulses/levels/hold counts out
interface tamagotchi_btn_conditioner_if;
    logic       btn_salud_n, btn_energia_n, btn_hambre_n, btn_diversion_n, btn_reset_n, btn_test_n;
    logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
    logic [2:0] count_reset, count_test;
    modport slave (
        input  btn_salud_n, btn_energia_n, btn_hambre_n, btn_diversion_n, btn_reset_n, btn_test_n,
        output btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test,
               count_reset, count_test
    );
    modport master (
        output btn_salud_n, btn_energia_n, btn_hambre_n, btn_diversion_n, btn_reset_n, btn_test_n,
        input  btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test,
               count_reset, count_test
    );
endinterface

// File: rtl/tamagotchi_btn_conditioner_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus debounce FSM; outputs debounced level and its rise indication
module btn_debounce
    import tamagotchi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic [CW-1:0] cnt, cnt_nx;
    db_state_t st, st_nx;
    logic level_q, synced, done;
    assign synced = sync[1];
    // the entering sample counts as the first stable one, so D-2 here means D samples in total
    assign done = cnt == CW'(DEBOUNCE_CYCLES - 2);
    assign level = st == PRESSED || st == RELEASE_PEND;
    assign rise = level && !level_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            st <= RELEASED;
            cnt <= '0;
            level_q <= 1'b0;
        end else begin
            sync <= {sync[0], ~raw_n};
            st <= st_nx;
            cnt <= cnt_nx;
            level_q <= level;
        end
    end
    always_comb begin
        st_nx = st;
        cnt_nx = cnt + 1'b1;
        case (st)
            RELEASED: begin
                cnt_nx = '0;
                st_nx = synced ? PRESS_PEND : RELEASED;
            end
            PRESS_PEND: st_nx = !synced ? RELEASED : (done ? PRESSED : PRESS_PEND);
            PRESSED: begin
                cnt_nx = '0;
                st_nx = !synced ? RELEASE_PEND : PRESSED;
            end
            default: st_nx = synced ? PRESSED : (done ? RELEASED : RELEASE_PEND);
        endcase
    end
endmodule

// File: rtl/tamagotchi_btn_conditioner.sv
// tamagotchi_btn_conditioner: debounced stat press pulses and reset/test held-seconds counters.
// TAMAGOTCHI_AUTOREPEAT_EN adds a once-per-second repeat pulse on held stat buttons.
module tamagotchi_btn_conditioner
    import tamagotchi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SEC_CYCLES = SEC_CYCLES_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input logic clk,
    input logic rst_n,
    tamagotchi_btn_conditioner_if.slave bus
);
    localparam int PW = $clog2(SEC_CYCLES + 1);
    logic [NUM_BTN-1:0] raw_n, lvl, rise;
    logic [3:0] pulse;
    logic [PW-1:0] hold_pre [2];
    logic [2:0] hold_cnt [2];
    assign raw_n = {bus.btn_test_n, bus.btn_reset_n, bus.btn_diversion_n,
                    bus.btn_hambre_n, bus.btn_energia_n, bus.btn_salud_n};
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .rst_n(rst_n), .raw_n(raw_n[g]), .level(lvl[g]), .rise(rise[g])
        );
    end
    // prescaler sits at 0 while released, so every new press starts a fresh second
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !lvl[RESET + i]) begin
                hold_pre[i] <= '0;
                hold_cnt[i] <= '0;
            end else if (hold_cnt[i] != 3'(HOLD_MAX)) begin
                hold_pre[i] <= (hold_pre[i] == PW'(SEC_CYCLES - 1)) ? '0 : hold_pre[i] + 1'b1;
                hold_cnt[i] <= hold_cnt[i] + 3'(hold_pre[i] == PW'(SEC_CYCLES - 1));
            end
        end
    end
`ifdef TAMAGOTCHI_AUTOREPEAT_EN
    logic [PW-1:0] rep_pre [4];
    logic [3:0] rep_hit;
    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < 4; i++) rep_hit[i] = lvl[i] && rep_pre[i] == PW'(SEC_CYCLES - 1);
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            rep_pre[i] <= (!rst_n || !lvl[i] || rise[i] || rep_hit[i]) ? '0 : rep_pre[i] + 1'b1;
        pulse <= !rst_n ? '0 : rise[3:0] | rep_hit;
    end
`else
    always_ff @(posedge clk) pulse <= !rst_n ? '0 : rise[3:0];
`endif
    assign bus.btn_salud = pulse[SALUD];
    assign bus.btn_energia = pulse[ENERGIA];
    assign bus.btn_hambre = pulse[HAMBRE];
    assign bus.btn_diversion = pulse[DIVERSION];
    assign bus.btn_reset = lvl[RESET];
    assign bus.btn_test = lvl[TEST];
    // counts read 0 the moment the level drops; the registers clear on the following edge
    assign bus.count_reset = lvl[RESET] ? hold_cnt[0] : '0;
    assign bus.count_test = lvl[TEST] ? hold_cnt[1] : '0;
endmodule

// File: tb/tb_tamagotchi_btn_conditioner.sv
// tb_tamagotchi_btn_conditioner: scoreboard bench comparing every cycle against a behavioural model
module tb_tamagotchi_btn_conditioner;
    localparam int D = 4;
    localparam int SEC = 10;
    localparam int HM = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] raw = '1;
    logic [11:0] exp_q [$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc_no = 0;
    bit m_s1 [6];
    bit m_s2 [6];
    bit m_lvl [6];
    bit m_rose [6];
    int m_run [6];
    int m_t [6];
    always #5 clk = ~clk;
    tamagotchi_btn_conditioner_if bus ();
    assign bus.btn_salud_n = raw[0];
    assign bus.btn_energia_n = raw[1];
    assign bus.btn_hambre_n = raw[2];
    assign bus.btn_diversion_n = raw[3];
    assign bus.btn_reset_n = raw[4];
    assign bus.btn_test_n = raw[5];
    tamagotchi_btn_conditioner #(.DEBOUNCE_CYCLES(D), .SEC_CYCLES(SEC), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    function automatic logic [11:0] got();
        return {bus.btn_diversion, bus.btn_hambre, bus.btn_energia, bus.btn_salud,
                bus.btn_reset, bus.btn_test, bus.count_reset, bus.count_test};
    endfunction
    function automatic logic [2:0] secs(int b);
        int s;
        s = m_t[b] / SEC;
        return m_lvl[b] ? 3'(s > HM ? HM : s) : 3'd0;
    endfunction
    // a level flips once the synchronised input has disagreed with it for D consecutive edges
    task automatic model();
        logic [3:0] p;
        bit old;
        int told;
        p = '0;
        cyc_no++;
        for (int b = 0; b < 6; b++) begin
            if (!rst_n) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_rose[b] = 0; m_run[b] = 0; m_t[b] = 0;
            end else begin
                old = m_lvl[b];
                told = m_t[b];
                if (b < 4) begin
                    p[b] = m_rose[b];
`ifdef TAMAGOTCHI_AUTOREPEAT_EN
                    if (old && told > 0 && told % SEC == 0) p[b] = 1'b1;
`endif
                end
                m_run[b] = (m_s2[b] != m_lvl[b]) ? m_run[b] + 1 : 0;
                if (m_run[b] == D) begin
                    m_lvl[b] = !m_lvl[b];
                    m_run[b] = 0;
                end
                m_rose[b] = !old && m_lvl[b];
                m_t[b] = (m_lvl[b] && old) ? told + 1 : 0;
                m_s2[b] = m_s1[b];
                m_s1[b] = !raw[b];
            end
        end
        exp_q.push_back({p, m_lvl[4], m_lvl[5], secs(4), secs(5)});
    endtask
    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            model();
            #1;
        end
    endtask
    always @(negedge clk) begin
        logic [11:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got();
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL outputs @cycle %0d: got %03h expected %03h", cyc_no, g, e);
        end
    end
    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        raw[0] = 1'b0; cyc(50); raw[0] = 1'b1; cyc(20);
        repeat (5) begin
            raw[1] = 1'b0; cyc(3); raw[1] = 1'b1; cyc(1);
        end
        cyc(15);
        raw[4] = 1'b0; cyc(80); raw[4] = 1'b1; cyc(20);
        raw[5] = 1'b0; cyc(25); raw[5] = 1'b1; cyc(10);
        raw[5] = 1'b0; cyc(30); raw[5] = 1'b1; cyc(15);
        raw[4] = 1'b0; cyc(40);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        cyc(40); raw[4] = 1'b1; cyc(15);
        raw[2] = 1'b0; cyc(40); raw[2] = 1'b1; cyc(15);
        raw[3:0] = '0; cyc(20); raw[3:0] = '1; cyc(15);
        for (int k = 0; k < 3000; k++) begin
            int pr;
            pr = ((k / 300) % 2) ? 30 : 2;
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 99) < pr) raw[b] = ~raw[b];
            rst_n = ($urandom_range(0, 999) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(5);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tamagotchi_btn_conditioner.md
Name: tamagotchi_btn_conditioner

Overview:
Upstream input stage for the tamagotchi state machine. Takes six raw, bouncy, active-low pushbuttons (salud, energia, hambre, diversion, reset, test) and synchronises and debounces each one. Stat buttons become single-cycle press pulses. Reset and test become debounced levels plus saturating 3-bit held-seconds counters, which drive the FSM's btn_* and count_reset/count_test inputs.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (20 ms at 50 MHz); must be >= 2
SEC_CYCLES, 50000000, clock cycles per held second
HOLD_MAX, 5, saturation value of the held-seconds counters; must be <= 7

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
btn_salud_n  input  1  raw salud button, active-low, asynchronous
btn_energia_n  input  1  raw energia button, active-low, asynchronous
btn_hambre_n  input  1  raw hambre button, active-low, asynchronous
btn_diversion_n  input  1  raw diversion button, active-low, asynchronous
btn_reset_n  input  1  raw reset button, active-low, asynchronous
btn_test_n  input  1  raw test button, active-low, asynchronous
btn_salud  output  1  one-cycle press pulse
btn_energia  output  1  one-cycle press pulse
btn_hambre  output  1  one-cycle press pulse
btn_diversion  output  1  one-cycle press pulse
btn_reset  output  1  debounced level, 1 while held
btn_test  output  1  debounced level, 1 while held
count_reset  output  3  whole seconds reset has been held, saturating at HOLD_MAX
count_test  output  3  whole seconds test has been held, saturating at HOLD_MAX

Behaviour:
- Reset: clk and rst_n only; rst_n is synchronous and active-low. While rst_n=0 on a clk edge, all outputs, counters and synchronisers clear to 0, and every debouncer enters RELEASED.
- Reset takes effect even mid-debounce or mid-hold. A button still physically held after reset must pass a full debounce before it is accepted.
- Inputs are inverted and passed through a 2-flop synchroniser per button.
- Per-button debounce FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - RELEASED -> PRESS_PEND on synced=1, stable counter cleared.
  - PRESS_PEND: counter +1 per cycle while synced=1. Any synced=0 returns to RELEASED. On reaching DEBOUNCE_CYCLES-1, go to PRESSED.
  - PRESSED and RELEASE_PEND mirror this with polarity swapped.
- Debounced level is 1 in PRESSED and RELEASE_PEND.
- Latency: debounced level rises exactly 2 + DEBOUNCE_CYCLES cycles after a clean raw falling edge; falls with the same latency after release.
- Stat pulse: registered, high for exactly one cycle, in the cycle after the debounced level rises. No pulse on release.
- Simultaneous stat presses are independent; each output pulses on its own.
- Hold timer (reset and test, independent):
  - Per-button prescaler and 3-bit count, both 0 while debounced level=0.
  - On the debounced rising edge the prescaler restarts at 0.
  - Every SEC_CYCLES cycles held, count increments; it saturates at HOLD_MAX and the prescaler then freezes.
  - count = 1 appears exactly SEC_CYCLES cycles after the debounced level rises.
  - Debounced release clears count and prescaler on the next clk edge.
- Bounces shorter than DEBOUNCE_CYCLES produce no output change.

Optional Feature:
Macro TAMAGOTCHI_AUTOREPEAT_EN.
- Defined: while a stat button remains debounced-pressed, it emits an additional one-cycle pulse every SEC_CYCLES cycles after the initial press pulse, with a per-stat-button prescaler.
- Undefined: exactly one pulse per press; no stat prescalers are synthesised.
- Reset and test behaviour is identical in both builds.

Decomposition:
- Package tamagotchi_pkg: HOLD_MAX default, button index constants (SALUD=0, ENERGIA=1, HAMBRE=2, DIVERSION=3, RESET=4, TEST=5), debounce state encoding, default cycle constants.
- Sub-module btn_debounce (synchroniser + debounce FSM, outputs level and rise pulse), instantiated six times.
- Hold timers and auto-repeat stay in the top module.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, SEC_CYCLES=10, HOLD_MAX=5.)
- Clean press of btn_salud_n low for 50 cycles -> btn_salud high for exactly one cycle, at cycle 7 after the edge; no pulse on release.
- btn_energia_n bounce, low 3 cycles / high 1 / low 3 / high, repeated -> btn_energia never pulses.
- btn_reset_n held low for 80 cycles -> btn_reset rises at cycle 6; count_reset=1 at cycle 16, 2 at 26, up to 5 at 56; stays 5; returns to 0 six cycles after release.
- btn_test_n held 25 cycles, released, pressed again -> count_test reaches 1, clears on release, and restarts from 0 with a fresh prescaler on re-press.
- rst_n=0 asserted mid-hold with count_reset=3 and btn_reset_n still low -> all outputs 0 next edge; after rst_n=1, btn_reset rises after a full 6-cycle debounce, and count_reset restarts from 0.
- With TAMAGOTCHI_AUTOREPEAT_EN defined, btn_hambre_n held 40 cycles -> btn_hambre pulses at cycles 7, 17, 27, 37; with the macro undefined -> only at cycle 7.
